// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the pipeline front end: load-use stalls, multi-cycle EX holds, branch flushes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MC_LAT       = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_mc_op,
    input  logic             ex_read_en,
    input  logic [4:0]       ex_rd,
    input  logic             br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             rfex_bubble,
    output logic             mc_kill,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);
    localparam logic [3:0] FL_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       lu_hazard;

    // Register 31 is the zero register, so a load targeting it never creates a dependency.
    assign lu_hazard = ex_read_en && (ex_rd != 5'd31) &&
                       ((id_use_rn && (id_rn == ex_rd)) ||
                        (id_use_rm && (id_rm == ex_rd)));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        rfex_bubble = 1'b0;
        mc_kill     = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;

        if (br_taken) begin
            ifid_flush  = 1'b1;
            rfex_bubble = 1'b1;
            mc_kill     = (state == MC_WAIT);
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = FL_LOAD;
            end else begin
                state_nxt = RUN;
                cnt_nxt   = 4'd0;
            end
        end else begin
            case (state)
                MC_WAIT: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    rfex_bubble = 1'b1;
                    cnt_nxt     = cnt - 4'd1;
                    if (cnt <= 4'd1) state_nxt = RUN;
                end
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    rfex_bubble = 1'b1;
                    cnt_nxt     = cnt - 4'd1;
                    if (cnt <= 4'd1) state_nxt = RUN;
                end
                default: begin
                    if (lu_hazard) begin
                        // One bubble suffices; EX->ID forwarding resolves the dependency afterwards.
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        rfex_bubble = 1'b1;
                    end else if (id_mc_op) begin
                        state_nxt = MC_WAIT;
                        cnt_nxt   = MC_LOAD;
                    end
                end
            endcase
        end

        // Held reset parks the front end: nothing fetched, NOPs loaded, no kill issued.
        if (!reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            rfex_bubble = 1'b1;
            mc_kill     = 1'b0;
        end
    end

    assign busy = reset && (state != RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int MC_LAT       = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [4:0]       id_rn = '0, id_rm = '0, ex_rd = '0;
    logic             id_use_rn = 1'b0, id_use_rm = 1'b0, id_mc_op = 1'b0;
    logic             ex_read_en = 1'b0, br_taken = 1'b0;
    logic             pc_en, ifid_en, ifid_flush, rfex_bubble, mc_kill, busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining hold / flush cycles and accumulated counts.
    int mc_left = 0, fl_left = 0, m_stall = 0, m_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .id_mc_op(id_mc_op), .ex_read_en(ex_read_en), .ex_rd(ex_rd), .br_taken(br_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .rfex_bubble(rfex_bubble),
        .mc_kill(mc_kill), .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_counters();
        check_val("stall_cnt", 32'(stall_cnt), PERF ? m_stall : 0);
        check_val("flush_cnt", 32'(flush_cnt), PERF ? m_flush : 0);
    endtask

    task automatic drive(input logic br, input logic mc, input logic rd_en, input logic [4:0] exrd,
                         input logic [4:0] rn, input logic [4:0] rm, input logic urn, input logic urm);
        br_taken = br; id_mc_op = mc; ex_read_en = rd_en; ex_rd = exrd;
        id_rn = rn; id_rm = rm; id_use_rn = urn; id_use_rm = urm;
    endtask

    // One clock cycle: check counters, apply inputs, check outputs, advance the model.
    task automatic step(input logic br, input logic mc, input logic rd_en, input logic [4:0] exrd,
                        input logic [4:0] rn, input logic [4:0] rm, input logic urn, input logic urm);
        bit lu, e_pc, e_en, e_fl, e_bub, e_kill, e_busy;
        @(negedge clk);
        check_counters();
        drive(br, mc, rd_en, exrd, rn, rm, urn, urm);
        #1;
        lu = rd_en && (exrd != 5'd31) && ((urn && rn == exrd) || (urm && rm == exrd));
        e_busy = (mc_left > 0) || (fl_left > 0);
        e_kill = 1'b0;
        if (br) begin
            e_pc = 1; e_en = 1; e_fl = 1; e_bub = 1; e_kill = (mc_left > 0);
            mc_left = 0; fl_left = FLUSH_CYCLES - 1;
        end else if (mc_left > 0) begin
            e_pc = 0; e_en = 0; e_fl = 0; e_bub = 1; mc_left--;
        end else if (fl_left > 0) begin
            e_pc = 1; e_en = 1; e_fl = 1; e_bub = 1; fl_left--;
        end else if (lu) begin
            e_pc = 0; e_en = 0; e_fl = 0; e_bub = 1;
        end else begin
            e_pc = 1; e_en = 1; e_fl = 0; e_bub = 0;
            if (mc) mc_left = MC_LAT - 1;
        end
        check_val("pc_en", 32'(pc_en), 32'(e_pc));
        check_val("ifid_en", 32'(ifid_en), 32'(e_en));
        check_val("ifid_flush", 32'(ifid_flush), 32'(e_fl));
        check_val("rfex_bubble", 32'(rfex_bubble), 32'(e_bub));
        check_val("mc_kill", 32'(mc_kill), 32'(e_kill));
        check_val("busy", 32'(busy), 32'(e_busy));
        if (!e_pc && m_stall < CNT_MAX) m_stall++;
        if (e_fl && m_flush < CNT_MAX) m_flush++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_pc_en", 32'(pc_en), 0);
        check_val("rst_ifid_en", 32'(ifid_en), 0);
        check_val("rst_ifid_flush", 32'(ifid_flush), 1);
        check_val("rst_rfex_bubble", 32'(rfex_bubble), 1);
        check_val("rst_mc_kill", 32'(mc_kill), 0);
        check_val("rst_busy", 32'(busy), 0);
    endtask

    // Assert reset at a negedge with the given branch input still applied, hold n cycles.
    task automatic do_reset(input int n, input logic br);
        @(negedge clk);
        br_taken = br;
        reset = 1'b0;
        #1;
        mc_left = 0; fl_left = 0; m_stall = 0; m_flush = 0;
        check_reset_outputs();
        check_counters();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_reset_outputs();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
    endtask

    initial begin
        do_reset(3, 1'b0);
        idle(2);

        // Load-use on Rm, then the same with the zero register, then on Rn.
        step(0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
        step(0, 0, 1, 5'd31, 5'd0, 5'd31, 0, 1);
        step(0, 0, 1, 5'd7, 5'd7, 5'd1, 1, 0);
        step(0, 0, 1, 5'd7, 5'd7, 5'd1, 0, 0);
        idle(1);

        // Multi-cycle op: MC_LAT-1 held cycles, hazards ignored meanwhile.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 5'd3, 5'd3, 5'd3, 1, 1);
        idle(4);

        // Branch pulse and back-to-back branches.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Branch on second MC_WAIT cycle with a load-use hazard present.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
        idle(3);

        // Counter saturation, then reset clears.
        for (int i = 0; i < 20; i++) step(0, 0, 1, 5'd2, 5'd2, 5'd2, 1, 1);
        do_reset(1, 1'b0);
        idle(2);

        // Reset in the middle of MC_WAIT with a branch pending: no kill.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        do_reset(1, 1'b1);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] rd, rn, rm;
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) rd = 5'd31;
            rn = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rm = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0),
                     1'($urandom_range(0, 1)), rd, rn, rm,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
